// File: rtl/filter_seq_pkg.sv
// Shared types and default widths for the pixel-filter frame sequencer,
// also used by the RAM and filter instantiations.
package filter_seq_pkg;

  localparam int ADDR_BITS_DEF  = 10;
  localparam int GREY_WIDTH_DEF = 8;
  localparam int PIX_WIDTH_DEF  = 3 * GREY_WIDTH_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    APPLY = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

endpackage

// File: rtl/pix_addr_cnt.sv
// Pixel address and written-count register pair for one frame.
// The terminal flag is the compare against the limit, so the increment never wraps.
module pix_addr_cnt #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 inc_i,
  input  logic [ADDR_BITS-1:0] limit_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 terminal_o,
  output logic [ADDR_BITS:0]   written_o
);

  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS:0]   written_q;

  assign terminal_o = (addr_q == limit_i);
  assign addr_o     = addr_q;
  assign written_o  = written_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      addr_q    <= '0;
      written_q <= '0;
    end else if (clear_i) begin
      addr_q    <= '0;
      written_q <= '0;
    end else if (inc_i) begin
      written_q <= written_q + 1'b1;
      // hold on the last address so a full-range frame stays in range
      if (!terminal_o) addr_q <= addr_q + 1'b1;
    end
  end

endmodule

// File: rtl/filter_seq_ctrl.sv
// Frame sequencer: walks the source RAM, feeds the filter, writes the grey result.
// Optional FILTER_SEQ_STEP_EN adds a step input that holds NEXT for single-stepping.
//
// state | meaning
// IDLE  | waiting for start, last frame's written count held
// READ  | source address presented to the RAM
// APPLY | RAM data valid, captured into pix_out
// WRITE | destination write strobe for the current pixel
// NEXT  | count the write, advance or finish (waits for step if enabled)
// DONE  | one-cycle completion pulse
module filter_seq_ctrl
  import filter_seq_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_BITS_DEF,
  parameter int PIX_WIDTH  = PIX_WIDTH_DEF,
  parameter int GREY_WIDTH = GREY_WIDTH_DEF
) (
`ifdef FILTER_SEQ_STEP_EN
  input  logic                  step,
`endif
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  last_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_BITS-1:0]  src_addr,
  input  logic [PIX_WIDTH-1:0]  src_data,
  output logic [PIX_WIDTH-1:0]  pix_out,
  input  logic [GREY_WIDTH-1:0] grey_in,
  output logic [ADDR_BITS-1:0]  dst_addr,
  output logic [PIX_WIDTH-1:0]  dst_data,
  output logic                  dst_we,
  output logic [ADDR_BITS:0]    written
);

  seq_state_e           state_q;
  logic [ADDR_BITS-1:0] last_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] dst_addr_q;
  logic [PIX_WIDTH-1:0] pix_q;

  logic                 step_ok;
  logic                 cnt_clear;
  logic                 cnt_inc;
  logic [ADDR_BITS-1:0] addr;
  logic                 terminal;

`ifdef FILTER_SEQ_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  assign cnt_clear = (state_q == IDLE) && start;
  assign cnt_inc   = (state_q == NEXT) && step_ok;

  pix_addr_cnt #(
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_cnt (
    .clk_i      (clk),
    .reset_i    (reset),
    .clear_i    (cnt_clear),
    .inc_i      (cnt_inc),
    .limit_i    (last_q),
    .addr_o     (addr),
    .terminal_o (terminal),
    .written_o  (written)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      dst_addr_q <= '0;
      pix_q      <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            last_q  <= last_addr;
            busy_q  <= 1'b1;
            state_q <= READ;
          end
        end
        READ: state_q <= APPLY;
        APPLY: begin
          pix_q      <= src_data;
          dst_addr_q <= addr;
          we_q       <= 1'b1;
          state_q    <= WRITE;
        end
        WRITE: state_q <= NEXT;
        NEXT: begin
          if (step_ok) begin
            if (terminal) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              state_q <= READ;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign src_addr = addr;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dst_we   = we_q;
  assign dst_addr = dst_addr_q;
  assign pix_out  = pix_q;
  assign dst_data = {3{grey_in}};

endmodule

// File: tb/tb_filter_seq_ctrl.sv
// Scoreboard bench for filter_seq_ctrl: expected writes and done pulses are queued
// by the stimulus and matched by a monitor on the falling edge.
module tb_filter_seq_ctrl;

  localparam int AB = 10;
  localparam int PW = 24;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AB-1:0] last_addr;
  logic          busy, done, dst_we;
  logic [AB-1:0] src_addr, dst_addr;
  logic [PW-1:0] src_data, pix_out, dst_data;
  logic [GW-1:0] grey_in;
  logic [AB:0]   written;
`ifdef FILTER_SEQ_STEP_EN
  logic          step;
`endif

  filter_seq_ctrl dut (
`ifdef FILTER_SEQ_STEP_EN
    .step      (step),
`endif
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .last_addr (last_addr),
    .busy      (busy),
    .done      (done),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .pix_out   (pix_out),
    .grey_in   (grey_in),
    .dst_addr  (dst_addr),
    .dst_data  (dst_data),
    .dst_we    (dst_we),
    .written   (written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [PW-1:0] src_mem [1024];
  int            wr_cnt  [1024];
  int            wr_snap [1024];

  always @(posedge clk) src_data <= src_mem[src_addr];

  function automatic logic [GW-1:0] filt(input logic [PW-1:0] p);
    int s;
    s = int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    return GW'(s / 3);
  endfunction

  always_comb grey_in = filt(pix_out);

  typedef struct {
    int            cyc;
    logic [AB-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_q[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (dst_we === 1'b1) begin
        wr_cnt[dst_addr] = wr_cnt[dst_addr] + 1;
        if (wr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d, none expected", dst_addr, dst_data, cyc);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("we_cycle", cyc, e.cyc);
          check("we_addr", 32'(dst_addr), 32'(e.addr));
          check("we_data", 32'(dst_data), 32'(e.data));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done at cycle %0d, none expected", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  task automatic push_wr(input int c, input int a, input logic [PW-1:0] d);
    wr_t e;
    e.cyc = c; e.addr = AB'(a); e.data = d;
    wr_q.push_back(e);
  endtask

  task automatic push_frame(input int base, input int first, input int last);
    for (int i = first; i <= last; i++)
      push_wr(base + 4*i + 3, i, {3{filt(src_mem[i])}});
  endtask

  task automatic launch(input int la, output int base);
    @(negedge clk);
    last_addr = AB'(la);
    start = 1'b1;
    base = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic end_frame(input string name, input int base, input int n);
    while (cyc < base + 4*n + 2) @(negedge clk);
    check({name, "_written"}, 32'(written), n);
    check({name, "_busy_idle"}, 32'(busy), 0);
    check({name, "_wr_left"}, wr_q.size(), 0);
    check({name, "_done_left"}, done_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int bad;
    logic [9:0] a;

    for (int i = 0; i < 1024; i++) begin
      a = 10'(i);
      src_mem[i] = {a[7:0], a[9:2] ^ 8'h5A, 8'(i * 3)};
      wr_cnt[i]  = 0;
    end
    src_mem[0] = 24'h060606;
    src_mem[1] = 24'hFF0000;
    src_mem[2] = 24'h000000;

    rst = 1'b1; start = 1'b0; last_addr = '0;
`ifdef FILTER_SEQ_STEP_EN
    step = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_we", 32'(dst_we), 0);
    check("rst_src_addr", 32'(src_addr), 0);
    check("rst_dst_addr", 32'(dst_addr), 0);
    check("rst_pix", 32'(pix_out), 0);
    check("rst_written", 32'(written), 0);

    // three-pixel frame with hand-computed grey values
    launch(2, base);
    push_wr(base + 3, 0, 24'h060606);
    push_wr(base + 7, 1, 24'h555555);
    push_wr(base + 11, 2, 24'h000000);
    done_q.push_back(base + 13);
    end_frame("f3", base, 3);

    // single pixel, busy window 1..5
    launch(0, base);
    push_wr(base + 3, 0, 24'h060606);
    done_q.push_back(base + 5);
    for (int c = 1; c <= 6; c++) begin
      check($sformatf("busy_c%0d", c), 32'(busy), (c <= 5) ? 1 : 0);
      @(negedge clk);
    end
    end_frame("f1", base, 1);

    // start and last_addr disturbed mid-frame
    launch(2, base);
    push_frame(base, 0, 2);
    done_q.push_back(base + 13);
    while (cyc < base + 6) @(negedge clk);
    start = 1'b1; last_addr = 10'd5;
    @(negedge clk);
    start = 1'b0;
    end_frame("disturb", base, 3);

    // held start: ignored in DONE, retriggers on the following IDLE cycle
    @(negedge clk);
    last_addr = '0; start = 1'b1; base = cyc;
    push_wr(base + 3, 0, 24'h060606);
    push_wr(base + 9, 0, 24'h060606);
    done_q.push_back(base + 5);
    done_q.push_back(base + 11);
    while (cyc < base + 7) @(negedge clk);
    start = 1'b0;
    end_frame("held", base + 6, 1);

    // full address range
    for (int i = 0; i < 1024; i++) wr_snap[i] = wr_cnt[i];
    launch(1023, base);
    push_frame(base, 0, 1023);
    done_q.push_back(base + 4097);
    end_frame("full", base, 1024);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (wr_cnt[i] != wr_snap[i] + 1) bad++;
    check("full_one_write_each", bad, 0);

    // reset during WRITE of pixel 5 of 10
    launch(9, base);
    push_frame(base, 0, 4);
    while (cyc < base + 22) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_we", 32'(dst_we), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_dst_addr", 32'(dst_addr), 0);
    check("mid_rst_src_addr", 32'(src_addr), 0);
    check("mid_rst_pix", 32'(pix_out), 0);
    check("mid_rst_written", 32'(written), 0);
    check("mid_rst_wr_left", wr_q.size(), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    launch(1, base);
    push_frame(base, 0, 1);
    done_q.push_back(base + 9);
    end_frame("after_rst", base, 2);

`ifdef FILTER_SEQ_STEP_EN
    // single-step: NEXT stalls until step
    launch(1, base);
    push_wr(base + 3, 0, {3{filt(src_mem[0])}});
    push_wr(base + 13, 1, {3{filt(src_mem[1])}});
    done_q.push_back(base + 21);
    while (cyc < base + 9) @(negedge clk);
    check("step_stall_busy", 32'(busy), 1);
    check("step_stall_written", 32'(written), 0);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    while (cyc < base + 19) @(negedge clk);
    check("step_stall2_busy", 32'(busy), 1);
    check("step_stall2_written", 32'(written), 1);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    while (cyc < base + 22) @(negedge clk);
    check("step_written", 32'(written), 2);
    check("step_busy_idle", 32'(busy), 0);
    check("step_wr_left", wr_q.size(), 0);
    check("step_done_left", done_q.size(), 0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/filter_seq_ctrl.md
Name: filter_seq_ctrl

Overview:
- Frame sequencer for the pixel-filter datapath.
- Walks a source pixel RAM from address 0 to a programmed last address and presents each pixel to the combinational black/white filter.
- Writes the replicated grey result into the destination RAM with a one-cycle write-enable pulse, then signals completion.
- Sits between the two synchronous single-port RAMs (read latency 1) and the filter, replacing free-running address logic with a start/busy/done handshake.

Parameters:
ADDR_BITS, 10, RAM address width for both RAMs
PIX_WIDTH, 24, RAM data width (3 x 8-bit channels)
GREY_WIDTH, 8, filter result width; PIX_WIDTH must equal 3*GREY_WIDTH

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
start  in  1  frame request, sampled only in IDLE
last_addr  in  ADDR_BITS  final pixel address (inclusive), captured when start is accepted
busy  out  1  high from accepted start until DONE state exits
done  out  1  single-cycle completion pulse
src_addr  out  ADDR_BITS  source RAM address
src_data  in  PIX_WIDTH  source RAM read data, valid one cycle after src_addr
pix_out  out  PIX_WIDTH  registered pixel driven to the filter
grey_in  in  GREY_WIDTH  filter result, combinational from pix_out
dst_addr  out  ADDR_BITS  destination RAM address
dst_data  out  PIX_WIDTH  {grey_in, grey_in, grey_in}
dst_we  out  1  destination write enable
written  out  ADDR_BITS+1  count of pixels written this frame, for the 7-seg display

Behaviour:
- Reset values:
  - state=IDLE.
  - busy, done, dst_we = 0.
  - src_addr, dst_addr, pix_out, written, captured last_addr = 0.
- States and transitions:
  - IDLE: start=1 -> captures last_addr, clears addr and written -> READ.
  - READ: src_addr=addr -> APPLY.
  - APPLY: pix_out <= src_data (RAM data now valid) -> WRITE.
  - WRITE: dst_addr=addr, dst_we=1 for exactly this cycle, dst_data={grey_in x3} -> NEXT.
  - NEXT: written increments here. If addr==captured last_addr -> DONE, else addr+1 -> READ.
  - DONE: done=1 for one cycle -> IDLE.
- Timing: 4 cycles per pixel.
  - With start sampled at edge 0 and N = last_addr+1, pixel i occupies cycles 4i+1..4i+4.
  - dst_we is high in cycle 4i+3.
  - done is high in cycle 4N+1.
  - busy is high in cycles 1..4N+1.
- Handshake and input handling:
  - start is ignored while busy, including the DONE cycle.
  - A held start re-triggers on the first IDLE cycle after DONE.
  - Changes to last_addr while busy have no effect.
- Address rules:
  - The terminal compare precedes the increment, so last_addr = 2^ADDR_BITS-1 completes without wrap.
  - addr never exceeds the captured last_addr.
  - last_addr=0 -> exactly one pixel, one write.
- Write enable: dst_we is never high outside WRITE; at most one write per address per frame.
- Counter: written is ADDR_BITS+1 wide and holds N after DONE until the next accepted start.
- Reset mid-frame: immediate return to IDLE, dst_we deasserts asynchronously, no done pulse. Already-written destination words are unaffected.

Optional Feature:
- Macro: FILTER_SEQ_STEP_EN.
- With the macro:
  - Extra input port step (1 bit).
  - NEXT holds until step=1, then transitions as normal; busy stays high while held.
  - Intended for single-stepping on the board with a debounced button.
  - Per-pixel latency becomes 4 cycles + wait.
- Without the macro: the step port is absent and NEXT always lasts one cycle.

Decomposition:
- Shared package filter_seq_pkg holds:
  - State enumeration: IDLE, READ, APPLY, WRITE, NEXT, DONE (3-bit encoding).
  - Default ADDR_BITS, PIX_WIDTH and GREY_WIDTH constants, shared with the RAM and filter instantiations.
- One natural sub-module: pix_addr_cnt.
  - Inputs: clear, inc, limit.
  - Outputs: addr, terminal flag, written count.
  - Same asynchronous reset.
- The FSM stays in the top.

Test Plan:
- Reset then start=1 for 1 cycle with last_addr=2, src RAM {0x060606, 0xFF0000, 0x000000}:
  - Three dst_we pulses at cycles 3, 7, 11 with addresses 0, 1, 2.
  - done at cycle 13; written=3.
- last_addr=0: one write to address 0; done at cycle 5; busy high for cycles 1..5 only.
- start pulsed again at cycle 6 of an active frame, and last_addr changed mid-frame: no restart, same write count and done timing as an undisturbed frame.
- last_addr=1023: 1024 writes, no write to any address twice, done at cycle 4097, written=1024.
- reset asserted during WRITE of pixel 5 of 10:
  - dst_we drops immediately, no done pulse, outputs return to reset values.
  - A fresh start rewrites from address 0.
- FILTER_SEQ_STEP_EN defined, last_addr=1:
  - Controller stalls in NEXT with busy=1 until step.
  - Two step pulses are needed before done.
